// File: rtl/link_freq_meter.sv
// Link frequency meter: synchronises the link square wave, averages valid periods
// over a window and divides CLK_HZ by the average to seed the PLL frequency word.
module link_freq_meter #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned F_DEFAULT  = 50000,
    parameter int unsigned MIN_PERIOD = 1000,
    parameter int unsigned MAX_PERIOD = 4000,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned TOL        = 16,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link,
    output logic [31:0] f_meas,
    output logic        f_valid,
    output logic [15:0] period_avg,
    output logic        freq_rdy,
    output logic        swiptAlive
);
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam int SCW = AVG_LOG2 + 1;
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]  MIN_C    = CW'(MIN_PERIOD);
    localparam logic [CW-1:0]  MAX_C    = CW'(MAX_PERIOD);
    localparam logic [CW-1:0]  TMO_C    = CW'(TIMEOUT);
    localparam logic [SCW-1:0] WIN_LAST = SCW'((1 << AVG_LOG2) - 1);
    localparam logic [15:0]    TOL_C    = 16'(TOL);
    localparam logic [LCW-1:0] LOCK_C   = LCW'(LOCK_CNT);

    typedef enum logic {SEARCH, MEASURE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     sync_q, sync_d;
    logic           edge_q, edge_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [19:0]    acc_q, acc_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic [LCW-1:0] stable_q, stable_d;
    logic [15:0]    prev_avg_q, prev_avg_d;
    logic           prev_vld_q, prev_vld_d;
    logic [15:0]    period_avg_q, period_avg_d;
    logic           freq_rdy_q, freq_rdy_d;
    logic           alive_q, alive_d;
    logic [31:0]    f_meas_q, f_meas_d;
    logic           f_valid_q, f_valid_d;
    logic           div_start_q, div_start_d;
    logic           div_busy_q, div_busy_d;
    logic [5:0]     div_n_q, div_n_d;
    logic [31:0]    div_quo_q, div_quo_d;
    logic [15:0]    div_rem_q, div_rem_d;
    logic [15:0]    div_dvs_q, div_dvs_d;

    logic           timeout;
    logic [19:0]    sum;
    logic [15:0]    avg, diff;
    logic [LCW-1:0] stable_inc;
    logic [16:0]    rem_sh;

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[1:0], link};
        edge_d       = sync_q[1] & ~sync_q[2];
        cnt_d        = (cnt_q == TMO_C) ? cnt_q : cnt_q + 1'b1;
        acc_d        = acc_q;
        scnt_d       = scnt_q;
        stable_d     = stable_q;
        prev_avg_d   = prev_avg_q;
        prev_vld_d   = prev_vld_q;
        period_avg_d = period_avg_q;
        freq_rdy_d   = freq_rdy_q;
        alive_d      = alive_q;
        f_meas_d     = f_meas_q;
        f_valid_d    = 1'b0;
        div_start_d  = 1'b0;
        div_busy_d   = div_busy_q;
        div_n_d      = div_n_q;
        div_quo_d    = div_quo_q;
        div_rem_d    = div_rem_q;
        div_dvs_d    = div_dvs_q;
        timeout      = (state_q == MEASURE) && (cnt_q == TMO_C);
        sum          = acc_q + 20'(cnt_q);
        avg          = 16'(sum >> AVG_LOG2);
        diff         = (avg >= prev_avg_q) ? avg - prev_avg_q : prev_avg_q - avg;
        stable_inc   = (stable_q == LOCK_C) ? stable_q : stable_q + 1'b1;
        rem_sh       = {div_rem_q, div_quo_q[31]};

        // Timeout outranks a coincident edge.
        if (timeout) begin
            state_d    = SEARCH;
            alive_d    = 1'b0;
            freq_rdy_d = 1'b0;
            f_meas_d   = 32'(F_DEFAULT);
            acc_d      = '0;
            scnt_d     = '0;
            stable_d   = '0;
            prev_avg_d = '0;
            prev_vld_d = 1'b0;
        end else if (edge_q) begin
            if (state_q == SEARCH) begin
                cnt_d   = CW'(1);
                state_d = MEASURE;
            end else if (cnt_q < MIN_C) begin
                cnt_d = (cnt_q == TMO_C) ? cnt_q : cnt_q + 1'b1;
            end else if (cnt_q <= MAX_C) begin
                cnt_d   = CW'(1);
                alive_d = 1'b1;
                if (scnt_q == WIN_LAST) begin
                    period_avg_d = avg;
                    acc_d        = '0;
                    scnt_d       = '0;
                    if (prev_vld_q && diff <= TOL_C) begin
                        stable_d = stable_inc;
                        if (stable_inc == LOCK_C) freq_rdy_d = 1'b1;
                    end else begin
                        stable_d   = '0;
                        freq_rdy_d = 1'b0;
                    end
                    prev_avg_d  = avg;
                    prev_vld_d  = 1'b1;
                    div_start_d = 1'b1;
                end else begin
                    acc_d  = sum;
                    scnt_d = scnt_q + 1'b1;
                end
            end else begin
                cnt_d      = CW'(1);
                acc_d      = '0;
                scnt_d     = '0;
                stable_d   = '0;
                freq_rdy_d = 1'b0;
            end
        end

        // Restoring divide CLK_HZ / period_avg; the dividend shifts out of the quotient register.
        if (timeout) begin
            div_busy_d = 1'b0;
            div_n_d    = '0;
        end else if (div_busy_q) begin
            if (div_n_q == 6'd32) begin
                f_meas_d   = div_quo_q;
                f_valid_d  = 1'b1;
                div_busy_d = 1'b0;
            end else begin
                div_n_d = div_n_q + 1'b1;
                if (rem_sh >= {1'b0, div_dvs_q}) begin
                    div_rem_d = 16'(rem_sh - {1'b0, div_dvs_q});
                    div_quo_d = {div_quo_q[30:0], 1'b1};
                end else begin
                    div_rem_d = rem_sh[15:0];
                    div_quo_d = {div_quo_q[30:0], 1'b0};
                end
            end
        end else if (div_start_q) begin
            div_busy_d = 1'b1;
            div_n_d    = '0;
            div_rem_d  = '0;
            div_quo_d  = 32'(CLK_HZ);
            div_dvs_d  = period_avg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEARCH;
            sync_q       <= '0;
            edge_q       <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            scnt_q       <= '0;
            stable_q     <= '0;
            prev_avg_q   <= '0;
            prev_vld_q   <= 1'b0;
            period_avg_q <= '0;
            freq_rdy_q   <= 1'b0;
            alive_q      <= 1'b0;
            f_meas_q     <= 32'(F_DEFAULT);
            f_valid_q    <= 1'b0;
            div_start_q  <= 1'b0;
            div_busy_q   <= 1'b0;
            div_n_q      <= '0;
            div_quo_q    <= '0;
            div_rem_q    <= '0;
            div_dvs_q    <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            edge_q       <= edge_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            scnt_q       <= scnt_d;
            stable_q     <= stable_d;
            prev_avg_q   <= prev_avg_d;
            prev_vld_q   <= prev_vld_d;
            period_avg_q <= period_avg_d;
            freq_rdy_q   <= freq_rdy_d;
            alive_q      <= alive_d;
            f_meas_q     <= f_meas_d;
            f_valid_q    <= f_valid_d;
            div_start_q  <= div_start_d;
            div_busy_q   <= div_busy_d;
            div_n_q      <= div_n_d;
            div_quo_q    <= div_quo_d;
            div_rem_q    <= div_rem_d;
            div_dvs_q    <= div_dvs_d;
        end
    end

    assign f_meas     = f_meas_q;
    assign f_valid    = f_valid_q;
    assign period_avg = period_avg_q;
    assign freq_rdy   = freq_rdy_q;
    assign swiptAlive = alive_q;
endmodule

// File: tb/tb_link_freq_meter.sv
// Bench for link_freq_meter, run with CLK_HZ and period limits scaled down by 10
// so 50 kHz is a 200-cycle period and 62.5 kHz a 160-cycle period.
module tb_link_freq_meter;
    localparam int CLK_HZ = 10000000;
    localparam int F_DEF  = 50000;
    localparam int MINP   = 100;
    localparam int MAXP   = 400;
    localparam int TOUT   = 800;

    logic        clk = 1'b0;
    logic        rst;
    logic        link;
    logic [31:0] f_meas;
    logic        f_valid;
    logic [15:0] period_avg;
    logic        freq_rdy;
    logic        swiptAlive;

    link_freq_meter #(
        .CLK_HZ(CLK_HZ), .F_DEFAULT(F_DEF), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
        .AVG_LOG2(2), .TOL(16), .LOCK_CNT(4), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .link(link), .f_meas(f_meas), .f_valid(f_valid),
        .period_avg(period_avg), .freq_rdy(freq_rdy), .swiptAlive(swiptAlive)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int per;
        int nper;
        bit glitch;
        int exp_pavg;
        int exp_fmeas;
        bit exp_rdy;
        bit exp_alive;
        bit exp_drop;
    } vec_t;
    vec_t vecs[4];

    int n_vec = 0;
    int n_bad = 0;

    // Link generator: per==0 holds the line low; a glitch adds a 5-cycle low notch 30 cycles in.
    int per = 0;
    int glitch_tok = 0;
    int rise_n = 0;
    int rise_cyc = 0;
    initial begin : gen
        int p;
        int seen;
        bit g;
        seen = 0;
        link = 1'b0;
        forever begin
            if (per == 0) begin
                link = 1'b0;
                @(negedge clk);
            end else begin
                p = per;
                g = (glitch_tok != seen);
                seen = glitch_tok;
                link = 1'b1;
                rise_cyc = cyc;
                rise_n++;
                if (g) begin
                    repeat (30) @(negedge clk);
                    link = 1'b0;
                    repeat (5) @(negedge clk);
                    link = 1'b1;
                    repeat (p / 2 - 35) @(negedge clk);
                end else begin
                    repeat (p / 2) @(negedge clk);
                end
                link = 1'b0;
                repeat (p - p / 2) @(negedge clk);
            end
        end
    end

    int fv_cyc[$];
    int fv_val[$];
    int alive_rise_n = 0;
    int alive_rise_cyc = -1;
    int fr_rise_n = 0;
    int fr_rise_cyc = -1;
    int fr_fall_n = 0;
    initial begin : mon
        logic alive_p;
        logic fr_p;
        alive_p = 1'b0;
        fr_p = 1'b0;
        forever begin
            @(negedge clk);
            if (f_valid === 1'b1) begin
                fv_cyc.push_back(cyc);
                fv_val.push_back(int'(f_meas));
            end
            if (swiptAlive === 1'b1 && alive_p !== 1'b1) begin
                alive_rise_n++;
                alive_rise_cyc = cyc;
            end
            if (freq_rdy === 1'b1 && fr_p !== 1'b1) begin
                fr_rise_n++;
                fr_rise_cyc = cyc;
            end
            if (freq_rdy === 1'b0 && fr_p === 1'b1) fr_fall_n++;
            alive_p = swiptAlive;
            fr_p = freq_rdy;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: stuck at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_rise(input int n0, input string name, output int r);
        int lim;
        lim = cyc + 2000;
        while (rise_n == n0 && cyc < lim) @(negedge clk);
        chk({name, " link_rise_seen"}, rise_n > n0, 1);
        r = rise_cyc;
    endtask

    // Start a clean link of period P from SEARCH and check the lock timeline.
    task automatic lock_seq(input int P, input int F, input string tag);
        int n0, fv0, r0, fvc, fvv;
        n0 = rise_n;
        fv0 = fv_cyc.size();
        @(posedge clk);
        per = P;
        wait_rise(n0, tag, r0);
        wait_until(r0 + 20 * P + 60);
        fvc = (fv_cyc.size() > fv0) ? fv_cyc[fv0] : -1;
        fvv = (fv_val.size() > fv0) ? fv_val[fv0] : -1;
        chk({tag, " alive_rise_cyc"}, alive_rise_cyc, r0 + P + 4);
        chk({tag, " first_fvalid_cyc"}, fvc, r0 + 4 * P + 38);
        chk({tag, " first_fvalid_fmeas"}, fvv, F);
        chk({tag, " period_avg"}, period_avg, P);
        chk({tag, " freq_rdy_rise_cyc"}, fr_rise_cyc, r0 + 20 * P + 4);
        chk({tag, " freq_rdy"}, freq_rdy, 1);
        chk({tag, " f_meas"}, f_meas, F);
    endtask

    initial begin : main
        int n0, fall0, r, rl, L, fv0, ar0, frr0;
        vecs[0] = '{200,  8, 1'b0, 200, 50000, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{200,  4, 1'b1, 200, 50000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{160, 30, 1'b0, 160, 62500, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{160,  6, 1'b1, 160, 62500, 1'b1, 1'b1, 1'b0};

        // Reset held with the link toggling.
        rst = 1'b1;
        per = 4;
        repeat (5) begin
            @(negedge clk);
            chk("rst f_meas", f_meas, F_DEF);
            chk("rst freq_rdy", freq_rdy, 0);
            chk("rst swiptAlive", swiptAlive, 0);
            chk("rst f_valid", f_valid, 0);
            chk("rst period_avg", period_avg, 0);
        end
        per = 0;
        repeat (10) @(negedge clk);
        rst = 1'b0;

        lock_seq(200, 50000, "lock200");

        foreach (vecs[i]) begin
            n0 = rise_n;
            fall0 = fr_fall_n;
            @(posedge clk);
            per = vecs[i].per;
            if (vecs[i].glitch) glitch_tok++;
            wait_rise(n0, $sformatf("vec%0d", i), r);
            wait_until(r + vecs[i].nper * vecs[i].per + 60);
            chk($sformatf("vec%0d period_avg", i), period_avg, vecs[i].exp_pavg);
            chk($sformatf("vec%0d f_meas", i), f_meas, vecs[i].exp_fmeas);
            chk($sformatf("vec%0d freq_rdy", i), freq_rdy, vecs[i].exp_rdy);
            chk($sformatf("vec%0d swiptAlive", i), swiptAlive, vecs[i].exp_alive);
            chk($sformatf("vec%0d rdy_dropped", i), fr_fall_n > fall0, vecs[i].exp_drop);
        end

        // Link loss while locked at 62.5 kHz: dead exactly TIMEOUT+1 cycles after the last edge.
        @(posedge clk);
        per = 0;
        wait_until(cyc + 300);
        rl = rise_cyc;
        wait_until(rl + TOUT + 3);
        chk("loss pre swiptAlive", swiptAlive, 1);
        chk("loss pre freq_rdy", freq_rdy, 1);
        chk("loss pre f_meas", f_meas, 62500);
        wait_until(rl + TOUT + 4);
        chk("loss swiptAlive", swiptAlive, 0);
        chk("loss freq_rdy", freq_rdy, 0);
        chk("loss f_meas", f_meas, F_DEF);
        chk("loss f_valid", f_valid, 0);

        lock_seq(200, 50000, "relock200");

        // Out-of-range period after a fresh reset.
        @(posedge clk);
        per = 0;
        wait_until(cyc + 300);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fv0 = fv_cyc.size();
        ar0 = alive_rise_n;
        frr0 = fr_rise_n;
        @(posedge clk);
        per = 500;
        wait_until(cyc + 5 * 500 + 50);
        chk("oor alive_rises", alive_rise_n - ar0, 0);
        chk("oor rdy_rises", fr_rise_n - frr0, 0);
        chk("oor fvalids", fv_cyc.size() - fv0, 0);
        chk("oor period_avg", period_avg, 0);
        chk("oor f_meas", f_meas, F_DEF);
        @(posedge clk);
        per = 0;
        wait_until(cyc + 1500);

        // Reset 10 cycles into the second divide of a 160-cycle link.
        n0 = rise_n;
        fv0 = fv_cyc.size();
        @(posedge clk);
        per = 160;
        wait_rise(n0, "middiv", r);
        L = r + 8 * 160 + 4;
        wait_until(L + 9);
        chk("middiv pre f_meas", f_meas, 62500);
        chk("middiv pre fvalids", fv_cyc.size() - fv0, 1);
        rst = 1'b1;
        per = 0;
        wait_until(L + 13);
        rst = 1'b0;
        wait_until(L + 60);
        chk("middiv fvalids", fv_cyc.size() - fv0, 1);
        chk("middiv f_meas", f_meas, F_DEF);
        chk("middiv freq_rdy", freq_rdy, 0);
        chk("middiv swiptAlive", swiptAlive, 0);
        chk("middiv period_avg", period_avg, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
